// File: rtl/bench_pkg.sv
// Shared types for the benchmark command dispatcher: command word layout and
// per-channel run-state encoding.
package bench_pkg;

    localparam int BENCH_CMD_W = 193;

    // First member lands in the MSBs, so is_write is bit 192 and base is [47:0].
    typedef struct packed {
        logic        is_write;
        logic [31:0] stride;
        logic [31:0] chunk;
        logic [31:0] n_acc;
        logic [47:0] size;
        logic [47:0] base;
    } bench_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        TOUT = 2'd3
    } bench_ch_state_e;

endpackage

// File: rtl/bench_chan_tracker.sv
// Per-channel run tracker: run state, saturating run counter, result latch and
// watchdog compare for one bench engine.
module bench_chan_tracker
    import bench_pkg::*;
#(
    parameter int CYC_W          = 64,
    parameter int DBG_W          = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             exec_valid_i,
    input  logic [CYC_W-1:0] exec_cycles_i,
    input  logic             clear_i,
    output logic             busy_o,
    output logic [DBG_W-1:0] run_cycles_o,
    output logic [CYC_W-1:0] result_o,
    output logic             tout_set_o
);

    localparam bit               TOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [DBG_W-1:0] TOUT_LAST = TOUT_EN ? DBG_W'(TIMEOUT_CYCLES - 1) : '0;

    bench_ch_state_e  state_q;
    logic [DBG_W-1:0] run_q;
    logic [CYC_W-1:0] result_q;
    logic             busy_q;
    logic             timeout_hit;

    // A result strobe in the last allowed cycle beats the watchdog.
    assign timeout_hit = TOUT_EN && (state_q == RUN) && !exec_valid_i && (run_q == TOUT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            run_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    run_q <= (&run_q) ? run_q : run_q + DBG_W'(1);
                    if (exec_valid_i) begin
                        state_q  <= DONE;
                        result_q <= exec_cycles_i;
                        busy_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q  <= TOUT;
                        result_q <= '1;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    if (start_i) begin
                        state_q <= RUN;
                        run_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (clear_i) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign run_cycles_o = run_q;
    assign result_o     = result_q;
    assign tout_set_o   = timeout_hit;

endmodule

// File: rtl/bench_dispatch_ctrl.sv
// Benchmark command dispatcher: accepts bench commands, starts one or all idle
// engines, holds the shared parameter set and collects per-channel status.
module bench_dispatch_ctrl
    import bench_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int DEST_W         = 4,
    parameter int CYC_W          = 64,
    parameter int DBG_W          = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    net_clk,
    input  logic                    net_areset,
    input  logic                    s_cmd_valid,
    output logic                    s_cmd_ready,
    input  logic [BENCH_CMD_W-1:0]  s_cmd_data,
    input  logic [DEST_W-1:0]       s_cmd_dest,
    input  logic                    s_cmd_bcast,
    output logic [47:0]             bench_base_addr,
    output logic [47:0]             bench_mem_size,
    output logic [31:0]             bench_num_acc,
    output logic [31:0]             bench_chunk_len,
    output logic [31:0]             bench_stride_len,
    output logic                    bench_is_write,
    output logic [NUM_CH-1:0]       bench_start,
    input  logic [NUM_CH-1:0]       exec_valid,
    input  logic [NUM_CH*CYC_W-1:0] exec_cycles,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*CYC_W-1:0] result_cycles,
    output logic [NUM_CH*DBG_W-1:0] run_cycles,
    output logic [NUM_CH-1:0]       timeout_flag,
    output logic                    err_busy,
    output logic                    err_dest,
    input  logic                    clear_status
);

    localparam logic [DEST_W:0] NUM_CH_EXT = (DEST_W + 1)'(NUM_CH);

    bench_cmd_t        cmd_in;
    bench_cmd_t        cmd_q;
    logic              ready_q;
    logic [NUM_CH-1:0] start_d;
    logic [NUM_CH-1:0] start_q;
    logic              err_busy_d, err_busy_q;
    logic              err_dest_d, err_dest_q;
    logic [NUM_CH-1:0] tout_flag_d, tout_flag_q;
    logic [NUM_CH-1:0] tout_set;
    logic              accept;
    logic              dest_ok;
    logic              hit_busy;
    logic              hit_dest;

    assign cmd_in  = s_cmd_data;
    assign accept  = s_cmd_valid & ready_q;
    assign dest_ok = ({1'b0, s_cmd_dest} < NUM_CH_EXT);

    // Rejected commands are still consumed; they only raise a sticky error.
    always_comb begin
        start_d  = '0;
        hit_busy = 1'b0;
        hit_dest = 1'b0;
        if (accept) begin
            if (s_cmd_bcast) begin
                start_d  = ~busy;
                hit_busy = |busy;
            end else if (!dest_ok) begin
                hit_dest = 1'b1;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (s_cmd_dest == DEST_W'(i)) begin
                        if (busy[i]) hit_busy = 1'b1;
                        else         start_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // A new error or timeout in the clearing cycle survives the clear.
    always_comb begin
        err_busy_d  = hit_busy | (err_busy_q & ~clear_status);
        err_dest_d  = hit_dest | (err_dest_q & ~clear_status);
        tout_flag_d = tout_set | (tout_flag_q & ~{NUM_CH{clear_status}});
    end

    always_ff @(posedge net_clk or posedge net_areset) begin
        if (net_areset) begin
            ready_q     <= 1'b0;
            cmd_q       <= '0;
            start_q     <= '0;
            err_busy_q  <= 1'b0;
            err_dest_q  <= 1'b0;
            tout_flag_q <= '0;
        end else begin
            ready_q     <= 1'b1;
            start_q     <= start_d;
            err_busy_q  <= err_busy_d;
            err_dest_q  <= err_dest_d;
            tout_flag_q <= tout_flag_d;
            if (|start_d) cmd_q <= cmd_in;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        bench_chan_tracker #(
            .CYC_W          (CYC_W),
            .DBG_W          (DBG_W),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_tracker (
            .clk_i         (net_clk),
            .rst_i         (net_areset),
            .start_i       (start_d[i]),
            .exec_valid_i  (exec_valid[i]),
            .exec_cycles_i (exec_cycles[i*CYC_W +: CYC_W]),
            .clear_i       (clear_status),
            .busy_o        (busy[i]),
            .run_cycles_o  (run_cycles[i*DBG_W +: DBG_W]),
            .result_o      (result_cycles[i*CYC_W +: CYC_W]),
            .tout_set_o    (tout_set[i])
        );
    end

    assign s_cmd_ready      = ready_q;
    assign bench_start      = start_q;
    assign bench_base_addr  = cmd_q.base;
    assign bench_mem_size   = cmd_q.size;
    assign bench_num_acc    = cmd_q.n_acc;
    assign bench_chunk_len  = cmd_q.chunk;
    assign bench_stride_len = cmd_q.stride;
    assign bench_is_write   = cmd_q.is_write;
    assign timeout_flag     = tout_flag_q;
    assign err_busy         = err_busy_q;
    assign err_dest         = err_dest_q;

endmodule

// File: tb/tb_bench_dispatch_ctrl.sv
// Scoreboard bench for bench_dispatch_ctrl: two channels with a 16-cycle watchdog.
module tb_bench_dispatch_ctrl;
    import bench_pkg::*;

    localparam int NUM_CH = 2;
    localparam int DEST_W = 4;
    localparam int CYC_W  = 64;
    localparam int DBG_W  = 32;
    localparam int TOUT   = 16;

    logic                    net_clk;
    logic                    net_areset;
    logic                    s_cmd_valid;
    logic                    s_cmd_ready;
    logic [BENCH_CMD_W-1:0]  s_cmd_data;
    logic [DEST_W-1:0]       s_cmd_dest;
    logic                    s_cmd_bcast;
    logic [47:0]             bench_base_addr;
    logic [47:0]             bench_mem_size;
    logic [31:0]             bench_num_acc;
    logic [31:0]             bench_chunk_len;
    logic [31:0]             bench_stride_len;
    logic                    bench_is_write;
    logic [NUM_CH-1:0]       bench_start;
    logic [NUM_CH-1:0]       exec_valid;
    logic [NUM_CH*CYC_W-1:0] exec_cycles;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH*CYC_W-1:0] result_cycles;
    logic [NUM_CH*DBG_W-1:0] run_cycles;
    logic [NUM_CH-1:0]       timeout_flag;
    logic                    err_busy;
    logic                    err_dest;
    logic                    clear_status;

    int nVectors     = 0;
    int nMiscompares = 0;

    logic [NUM_CH-1:0] startQ[$];
    logic [CYC_W-1:0]  resultQ[$];

    bench_dispatch_ctrl #(
        .NUM_CH(NUM_CH), .DEST_W(DEST_W), .CYC_W(CYC_W), .DBG_W(DBG_W), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .net_clk(net_clk), .net_areset(net_areset),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_data(s_cmd_data),
        .s_cmd_dest(s_cmd_dest), .s_cmd_bcast(s_cmd_bcast),
        .bench_base_addr(bench_base_addr), .bench_mem_size(bench_mem_size),
        .bench_num_acc(bench_num_acc), .bench_chunk_len(bench_chunk_len),
        .bench_stride_len(bench_stride_len), .bench_is_write(bench_is_write),
        .bench_start(bench_start), .exec_valid(exec_valid), .exec_cycles(exec_cycles),
        .busy(busy), .result_cycles(result_cycles), .run_cycles(run_cycles),
        .timeout_flag(timeout_flag), .err_busy(err_busy), .err_dest(err_dest),
        .clear_status(clear_status)
    );

    initial net_clk = 1'b0;
    always #5 net_clk = ~net_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge net_clk);
        #1;
    endtask

    function automatic logic [BENCH_CMD_W-1:0] makeCmd(input logic [47:0] base, input logic [31:0] nAcc,
                                                       input logic wr);
        bench_cmd_t c;
        c.base     = base;
        c.size     = 48'h0001_0000;
        c.n_acc    = nAcc;
        c.chunk    = 32'd64;
        c.stride   = 32'd128;
        c.is_write = wr;
        return c;
    endfunction

    function automatic logic [CYC_W-1:0] resultOf(input int ch);
        return result_cycles[ch*CYC_W +: CYC_W];
    endfunction

    // Drives one command for one cycle; the start pulse shows up right after that edge.
    task automatic applyStimulus(input logic [DEST_W-1:0] dest, input logic bcast,
                                 input logic [BENCH_CMD_W-1:0] data, input logic [NUM_CH-1:0] expStart);
        s_cmd_valid = 1'b1;
        s_cmd_dest  = dest;
        s_cmd_bcast = bcast;
        s_cmd_data  = data;
        startQ.push_back(expStart);
        tick();
        s_cmd_valid = 1'b0;
        s_cmd_bcast = 1'b0;
        checkOutput("bench_start", {62'd0, bench_start}, {62'd0, startQ.pop_front()});
    endtask

    task automatic finishChannels(input logic [NUM_CH-1:0] mask, input logic [63:0] v0, input logic [63:0] v1);
        exec_valid  = mask;
        exec_cycles = {v1, v0};
        if (mask[0]) resultQ.push_back(v0);
        if (mask[1]) resultQ.push_back(v1);
        tick();
        exec_valid = '0;
        if (mask[0]) checkOutput("result_ch0", resultOf(0), resultQ.pop_front());
        if (mask[1]) checkOutput("result_ch1", resultOf(1), resultQ.pop_front());
        checkOutput("busy_after_done", {62'd0, busy & mask}, 64'd0);
    endtask

    task automatic pulseClear();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    initial begin
        int n;
        net_areset   = 1'b1;
        s_cmd_valid  = 1'b0;
        s_cmd_data   = '0;
        s_cmd_dest   = '0;
        s_cmd_bcast  = 1'b0;
        exec_valid   = '0;
        exec_cycles  = '0;
        clear_status = 1'b0;
        tick();
        tick();
        checkOutput("rst_ready", {63'd0, s_cmd_ready}, 64'd0);
        checkOutput("rst_busy", {62'd0, busy}, 64'd0);
        checkOutput("rst_start", {62'd0, bench_start}, 64'd0);
        checkOutput("rst_base", {16'd0, bench_base_addr}, 64'd0);
        checkOutput("rst_errs", {61'd0, err_busy, err_dest, |timeout_flag}, 64'd0);
        net_areset = 1'b0;
        #1;
        checkOutput("ready_pre", {63'd0, s_cmd_ready}, 64'd0);
        tick();
        checkOutput("ready_post", {63'd0, s_cmd_ready}, 64'd1);

        $display("[TB] unicast");
        applyStimulus(4'd1, 1'b0, makeCmd(48'h1000, 32'd8, 1'b1), 2'b10);
        checkOutput("uc_base", {16'd0, bench_base_addr}, 64'h1000);
        checkOutput("uc_nacc", {32'd0, bench_num_acc}, 64'd8);
        checkOutput("uc_wr", {63'd0, bench_is_write}, 64'd1);
        checkOutput("uc_busy", {62'd0, busy}, 64'b10);
        checkOutput("uc_run0", {32'd0, run_cycles[DBG_W +: DBG_W]}, 64'd0);
        tick();
        checkOutput("uc_pulse_end", {62'd0, bench_start}, 64'd0);
        finishChannels(2'b10, 64'd0, 64'h55);

        $display("[TB] busy reject");
        applyStimulus(4'd0, 1'b0, makeCmd(48'h2000, 32'd4, 1'b0), 2'b01);
        applyStimulus(4'd0, 1'b0, makeCmd(48'h3000, 32'd5, 1'b1), 2'b00);
        checkOutput("rej_err_busy", {63'd0, err_busy}, 64'd1);
        checkOutput("rej_base", {16'd0, bench_base_addr}, 64'h2000);
        checkOutput("rej_nacc", {32'd0, bench_num_acc}, 64'd4);
        finishChannels(2'b01, 64'hAA, 64'd0);
        pulseClear();
        checkOutput("clr_err_busy", {63'd0, err_busy}, 64'd0);

        $display("[TB] broadcast");
        applyStimulus(4'd1, 1'b0, makeCmd(48'h4000, 32'd1, 1'b0), 2'b10);
        applyStimulus(4'd0, 1'b1, makeCmd(48'h5000, 32'd2, 1'b0), 2'b01);
        checkOutput("bc_err_busy", {63'd0, err_busy}, 64'd1);
        checkOutput("bc_base", {16'd0, bench_base_addr}, 64'h5000);
        applyStimulus(4'd0, 1'b1, makeCmd(48'h6000, 32'd3, 1'b0), 2'b00);
        checkOutput("bc_allbusy_base", {16'd0, bench_base_addr}, 64'h5000);
        applyStimulus(4'd3, 1'b0, makeCmd(48'h7000, 32'd3, 1'b0), 2'b00);
        checkOutput("dest_err", {63'd0, err_dest}, 64'd1);
        checkOutput("dest_base", {16'd0, bench_base_addr}, 64'h5000);
        pulseClear();
        checkOutput("clr_flags", {62'd0, err_busy, err_dest}, 64'd0);
        checkOutput("clr_run_kept", {62'd0, busy}, 64'b11);
        finishChannels(2'b11, 64'h111, 64'h222);

        $display("[TB] timeout");
        applyStimulus(4'd0, 1'b0, makeCmd(48'h8000, 32'd9, 1'b0), 2'b01);
        n = 0;
        while (busy[0] && n < 40) begin
            tick();
            n++;
        end
        checkOutput("tout_latency", 64'(n), 64'd16);
        resultQ.push_back('1);
        checkOutput("tout_result", resultOf(0), resultQ.pop_front());
        checkOutput("tout_flag", {62'd0, timeout_flag}, 64'b01);
        exec_valid  = 2'b01;
        exec_cycles = {64'd0, 64'h77};
        tick();
        exec_valid = '0;
        checkOutput("late_ignored", resultOf(0), 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("late_busy", {62'd0, busy}, 64'd0);
        pulseClear();
        checkOutput("clr_tout", {62'd0, timeout_flag}, 64'd0);

        $display("[TB] race");
        applyStimulus(4'd1, 1'b0, makeCmd(48'h9000, 32'd7, 1'b0), 2'b10);
        for (int k = 0; k < TOUT - 1; k++) tick();
        checkOutput("race_run", {32'd0, run_cycles[DBG_W +: DBG_W]}, 64'(TOUT - 1));
        checkOutput("race_busy", {62'd0, busy}, 64'b10);
        finishChannels(2'b10, 64'd0, 64'h1234);
        checkOutput("race_flag", {62'd0, timeout_flag}, 64'd0);

        $display("[TB] reset mid-run");
        applyStimulus(4'd0, 1'b1, makeCmd(48'hA000, 32'd6, 1'b1), 2'b11);
        checkOutput("mr_busy", {62'd0, busy}, 64'b11);
        #2;
        net_areset = 1'b1;
        #1;
        checkOutput("mr_busy_clr", {62'd0, busy}, 64'd0);
        checkOutput("mr_ready_clr", {63'd0, s_cmd_ready}, 64'd0);
        checkOutput("mr_result1", resultOf(1), 64'd0);
        tick();
        net_areset = 1'b0;
        #1;
        checkOutput("mr_ready_pre", {63'd0, s_cmd_ready}, 64'd0);
        tick();
        checkOutput("mr_ready_post", {63'd0, s_cmd_ready}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
